// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable FIFO family: counter width,
// pointer wrap helper and the read-mode enumeration.
package fifo_pkg;

    typedef enum logic [0:0] {
        FWFT_OFF = 1'b0,
        FWFT_ON  = 1'b1
    } fwft_mode_e;

    // Occupancy counter width: must hold every value 0..depth inclusive.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer increment with an explicit wrap, so non-power-of-two depths
    // never produce a pointer at or beyond depth.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        if (ptr == (depth - 32'd1)) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_prog_chk.sv
// Invariant checker for fifo_prog: bounds on count/pointers, status pulse
// consistency and flush behaviour.
module fifo_prog_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4,
    parameter int PW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    input logic [CW-1:0] count,
    input logic [PW-1:0] wr_ptr,
    input logic [PW-1:0] rd_ptr,
    input logic          wr_ack,
    input logic          overflow,
    input logic          underflow,
    input logic          full,
    input logic          empty
);

    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_wr_ptr_rng: assert property (@(posedge clk) disable iff (rst) 32'(wr_ptr) < DEPTH);
    a_rd_ptr_rng: assert property (@(posedge clk) disable iff (rst) 32'(rd_ptr) < DEPTH);
    a_ack_ovf_excl: assert property (@(posedge clk) disable iff (rst) !(wr_ack && overflow));
    a_ovf_full: assert property (@(posedge clk) disable iff (rst) overflow |-> $past(full));
    a_ack_notfull: assert property (@(posedge clk) disable iff (rst) wr_ack |-> !$past(full));
    a_udf_empty: assert property (@(posedge clk) disable iff (rst) underflow |-> $past(empty));
    a_flush_zero: assert property (@(posedge clk) disable iff (rst) flush |=> (count == CW'(0)));

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Wrapping read/write pointers, occupancy counter and accept decisions.
// Acceptance looks only at the registered count, never at the other side's
// same-cycle action.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 4,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_accept,
    output logic          rd_accept,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_acc_s, rd_acc_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == CW'(0));
    assign wr_acc_s  = wr_en && !full && !flush;
    assign rd_acc_s  = rd_en && !empty && !flush;
    assign wr_accept = wr_acc_s;
    assign rd_accept = rd_acc_s;
    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign count     = count_q;

    // Next pointer and occupancy; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fifo_prog.sv
// Programmable-depth single-clock FIFO with runtime thresholds, flush,
// occupancy output and build-time standard / first-word-fall-through read.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int FWFT       = 0,
    localparam int CW         = calc_cw(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [CW-1:0]         af_level,
    input  logic [CW-1:0]         ae_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    localparam int         PW   = $clog2(FIFO_DEPTH);
    localparam fwft_mode_e MODE = (FWFT != 0) ? FWFT_ON : FWFT_OFF;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_s, rd_ptr_s;
    logic [CW-1:0]         count_s;
    logic                  wr_acc_s, rd_acc_s, full_s, empty_s;
    logic                  wr_ack_q, overflow_q, underflow_q;

    fifo_ptr_ctrl #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW),
        .PW    (PW)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_accept (wr_acc_s),
        .rd_accept (rd_acc_s),
        .wr_ptr    (wr_ptr_s),
        .rd_ptr    (rd_ptr_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign count       = count_s;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almostfull  = (count_s >= af_level);
    assign almostempty = (count_s <= ae_level);
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Storage array: written on accepted writes, never cleared.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_s] <= data_in;
        end else begin
            mem_q[wr_ptr_s] <= mem_q[wr_ptr_s];
        end
    end

    // One-cycle status pulses describing the previous cycle's requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_acc_s;
            overflow_q  <= wr_en && full_s && !flush;
            underflow_q <= rd_en && empty_s && !flush;
        end
    end

    generate
        if (MODE == FWFT_OFF) begin : g_std
            logic [FIFO_WIDTH-1:0] data_q;
            logic                  valid_q;

            // Registered read port: load the head on an accepted pop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= {FIFO_WIDTH{1'b0}};
                    valid_q <= 1'b0;
                end else begin
                    if (rd_acc_s) begin
                        data_q <= mem_q[rd_ptr_s];
                    end else begin
                        data_q <= data_q;
                    end
                    valid_q <= rd_acc_s;
                end
            end

            assign data_out   = data_q;
            assign data_valid = valid_q;
        end else begin : g_fwft
            assign data_out   = mem_q[rd_ptr_s];
            assign data_valid = !empty_s;
        end
    endgenerate

    fifo_prog_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW),
        .PW    (PW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .count     (count_s),
        .wr_ptr    (wr_ptr_s),
        .rd_ptr    (rd_ptr_s),
        .wr_ack    (wr_ack_q),
        .overflow  (overflow_q),
        .underflow (underflow_q),
        .full      (full_s),
        .empty     (empty_s)
    );

endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: a standard-read and an FWFT instance share one
// stimulus stream and are compared every cycle against a queue model,
// plus directed literal expectations.
module tb_fifo_prog;

    localparam int W = 16;
    localparam int D = 6;

    logic          clk = 1'b0;
    logic          rst, flush, wr_en, rd_en;
    logic [W-1:0]  data_in;
    logic [2:0]    af_level, ae_level;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_dv, f_dv, s_ack, f_ack, s_ovf, f_ovf, s_udf, f_udf;
    logic          s_full, f_full, s_empty, f_empty, s_af, f_af, s_ae, f_ae;
    logic [2:0]    s_cnt, f_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    logic [W-1:0]  q [$];
    logic          m_ack = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, m_dv = 1'b0;
    logic [W-1:0]  m_dout = '0;

    always #5 clk = ~clk;

    fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .af_level(af_level), .ae_level(ae_level),
        .data_out(s_dout), .data_valid(s_dv), .wr_ack(s_ack), .overflow(s_ovf),
        .underflow(s_udf), .full(s_full), .empty(s_empty), .almostfull(s_af),
        .almostempty(s_ae), .count(s_cnt)
    );

    fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .af_level(af_level), .ae_level(ae_level),
        .data_out(f_dout), .data_valid(f_dv), .wr_ack(f_ack), .overflow(f_ovf),
        .underflow(f_udf), .full(f_full), .empty(f_empty), .almostfull(f_af),
        .almostempty(f_ae), .count(f_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words plus last-cycle request outcomes.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0;
                m_dout = '0;
            end else begin
                int  n;
                bit  wa, ra;
                n     = q.size();
                wa    = wr_en && (n < D) && !flush;
                ra    = rd_en && (n > 0) && !flush;
                m_ack = wa;
                m_ovf = wr_en && (n == D) && !flush;
                m_udf = rd_en && (n == 0) && !flush;
                m_dv  = ra;
                if (ra) m_dout = q.pop_front();
                if (wa) q.push_back(data_in);
                if (flush) q.delete();
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int n;
                n = q.size();
                chk("s_count", int'(s_cnt), n);
                chk("f_count", int'(f_cnt), n);
                chk("s_full", int'(s_full), int'(n == D));
                chk("s_empty", int'(s_empty), int'(n == 0));
                chk("f_empty", int'(f_empty), int'(n == 0));
                chk("s_almostfull", int'(s_af), int'(n >= int'(af_level)));
                chk("s_almostempty", int'(s_ae), int'(n <= int'(ae_level)));
                chk("f_almostfull", int'(f_af), int'(n >= int'(af_level)));
                chk("s_wr_ack", int'(s_ack), int'(m_ack));
                chk("f_wr_ack", int'(f_ack), int'(m_ack));
                chk("s_overflow", int'(s_ovf), int'(m_ovf));
                chk("f_overflow", int'(f_ovf), int'(m_ovf));
                chk("s_underflow", int'(s_udf), int'(m_udf));
                chk("f_underflow", int'(f_udf), int'(m_udf));
                chk("s_data_valid", int'(s_dv), int'(m_dv));
                chk("s_data_out", int'(s_dout), int'(m_dout));
                chk("f_data_valid", int'(f_dv), int'(n > 0));
                if (n > 0) chk("f_data_out", int'(f_dout), int'(q[0]));
            end
        end
    end

    // One bus cycle: drive just after an edge, return just after the next one.
    task automatic cyc(input bit w, input logic [W-1:0] d, input bit r, input bit f);
        wr_en = w; data_in = d; rd_en = r; flush = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        af_level = 3'd4; ae_level = 3'd1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_count", int'(s_cnt), 0);
        chk("rst_empty", int'(s_empty), 1);
        chk("rst_dout", int'(s_dout), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // fill, then one write too many
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 16'(i + 1), 1'b0, 1'b0);
            chk("fill_ack", int'(s_ack), 1);
        end
        chk("fill_count", int'(s_cnt), 6);
        chk("fill_full", int'(s_full), 1);
        cyc(1'b1, 16'h0007, 1'b0, 1'b0);
        chk("fill_ovf", int'(s_ovf), 1);
        chk("fill_count7", int'(s_cnt), 6);

        // drain in order, then one read too many
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0);
            chk("drain_data", int'(s_dout), i + 1);
            chk("drain_dv", int'(s_dv), 1);
        end
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("drain_udf", int'(s_udf), 1);
        chk("drain_empty", int'(s_empty), 1);
        chk("drain_dv_off", int'(s_dv), 0);

        // pointer wrap: 4 in/out, then 6 in/out
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h00A0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0);
            chk("wrap1_data", int'(s_dout), 16'h00A0 + i);
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h00A4 + i), 1'b0, 1'b0);
        chk("wrap_full", int'(s_full), 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0);
            chk("wrap2_data", int'(s_dout), 16'h00A4 + i);
        end
        chk("wrap_count", int'(s_cnt), 0);

        // simultaneous read and write at full and at empty
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'h00EE, 1'b1, 1'b0);
        chk("sim_full_data", int'(s_dout), 16'h0010);
        chk("sim_full_ovf", int'(s_ovf), 1);
        chk("sim_full_count", int'(s_cnt), 5);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b1, 16'h0077, 1'b1, 1'b0);
        chk("sim_empty_ack", int'(s_ack), 1);
        chk("sim_empty_udf", int'(s_udf), 1);
        chk("sim_empty_count", int'(s_cnt), 1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("sim_empty_data", int'(s_dout), 16'h0077);

        // thresholds and flush
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0030 + i), 1'b0, 1'b0);
        chk("af_at3", int'(s_af), 0);
        cyc(1'b1, 16'h0033, 1'b0, 1'b0);
        chk("af_at4", int'(s_af), 1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("flush_count", int'(s_cnt), 0);
        chk("flush_empty", int'(s_empty), 1);
        chk("flush_ae", int'(s_ae), 1);
        chk("flush_dout_hold", int'(s_dout), 16'h0077);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("flush_udf", int'(s_udf), 1);

        // thresholds above depth saturate
        af_level = 3'd7; ae_level = 3'd7;
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h0040 + i), 1'b0, 1'b0);
        chk("sat_af", int'(s_af), 0);
        chk("sat_ae", int'(s_ae), 1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        af_level = 3'd4; ae_level = 3'd1;

        // FWFT head visible without a read
        cyc(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("fwft_data", int'(f_dout), 16'h1234);
        chk("fwft_dv", int'(f_dv), 1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("fwft_dv_off", int'(f_dv), 0);

        // asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0050 + i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst_s_count", int'(s_cnt), 0);
        chk("async_rst_f_count", int'(f_cnt), 0);
        chk("async_rst_empty", int'(f_empty), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
